// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : song_sequencer
// Purpose  : Walks one song in the note ROM and hands each {note, duration}
//            to the note player, then reports the end of the song.
// Revision : 1.0
// ============================================================================
module song_sequencer #(
    parameter int NOTE_IDX_W = 5,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic                    reset_play,
    input  logic [1:0]              song,
    output logic [NOTE_IDX_W+1:0]   rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic                    new_note,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    input  logic                    note_done,
    output logic                    song_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_ROM  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_NOTE = 3'd4,
        S_END       = 3'd5
    } state_t;

    localparam logic [NOTE_IDX_W-1:0] C_LAST_IDX = '1;
    localparam logic [NOTE_IDX_W-1:0] C_IDX_ONE  = NOTE_IDX_W'(1);

    state_t                state_q, state_d;
    logic [NOTE_IDX_W-1:0] idx_q,   idx_d;
    logic [NOTE_W-1:0]     note_q,  note_d;
    logic [DUR_W-1:0]      dur_q,   dur_d;

    logic [NOTE_W-1:0]     w_rom_note;
    logic [DUR_W-1:0]      w_rom_dur;

    assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur  = rom_data[DUR_W-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        note_d  = note_q;
        dur_d   = dur_q;
        if (reset_play) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE:      if (play) state_d = S_FETCH;
                S_FETCH:     if (play) state_d = S_WAIT_ROM;
                S_WAIT_ROM: begin
                    // A zero duration is the end-of-song marker, not a note.
                    if (play) begin
                        if (w_rom_dur == '0) begin
                            state_d = S_END;
                        end else begin
                            note_d  = w_rom_note;
                            dur_d   = w_rom_dur;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_ISSUE:     if (play) state_d = S_WAIT_NOTE;
                S_WAIT_NOTE: begin
                    if (note_done) begin
                        if (idx_q == C_LAST_IDX) begin
                            state_d = S_END;
                        end else begin
                            idx_d   = idx_q + C_IDX_ONE;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_END: begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
        end
    end

    // Strobes come from registered state but must honour pause and restart
    // in the very cycle they occur.
    assign new_note  = (state_q == S_ISSUE) && play && !reset_play;
    assign song_done = (state_q == S_END) && !reset_play;
    assign rom_addr  = {song, idx_q};
    assign note      = note_q;
    assign duration  = dur_q;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_song_sequencer
// Purpose  : Self-checking bench for song_sequencer against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset, play, reset_play, note_done;
    logic [1:0]  song;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic        new_note, song_done;
    logic [5:0]  note, duration;

    logic [11:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    song_sequencer #(.NOTE_IDX_W(5), .NOTE_W(6), .DUR_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .reset_play (reset_play),
        .song       (song),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .new_note   (new_note),
        .note       (note),
        .duration   (duration),
        .note_done  (note_done),
        .song_done  (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a song is a list of words; the player is either
    // idle, working through the 3-step fetch/issue pipeline of one word,
    // waiting on the note player, or announcing the end of the song.
    // ------------------------------------------------------------------
    bit          m_busy, m_wait, m_end;
    int          m_step, m_idx;
    logic [5:0]  m_note, m_dur;
    logic [11:0] m_word;
    logic        exp_nn, exp_sd;

    int          cyc = 0, nn_cnt = 0, sd_cnt = 0;
    int          last_nn_cyc = 0, last_sd_cyc = 0, last_nn_idx = 0;
    logic [5:0]  last_nn_note;
    int          idx_log [$];

    initial begin
        m_busy = 0; m_wait = 0; m_end = 0; m_step = 0; m_idx = 0;
        m_note = '0; m_dur = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                m_busy = 0; m_wait = 0; m_end = 0; m_step = 0; m_idx = 0;
                m_note = '0; m_dur = '0;
                chk("rst_rom_addr", rom_addr, {song, 5'd0});
                chk("rst_new_note", new_note, 0);
                chk("rst_song_done", song_done, 0);
                chk("rst_note", note, 0);
                chk("rst_duration", duration, 0);
            end else begin
                exp_nn = m_busy && (m_step == 2) && play && !reset_play;
                exp_sd = m_end && !reset_play;
                chk("rom_addr", rom_addr, {song, m_idx[4:0]});
                chk("new_note", new_note, exp_nn);
                chk("song_done", song_done, exp_sd);
                chk("note", note, m_note);
                chk("duration", duration, m_dur);
                chk("strobe_overlap", new_note && song_done, 0);
                if (new_note === 1'b1) begin
                    nn_cnt++; last_nn_cyc = cyc; last_nn_note = note; last_nn_idx = m_idx;
                    idx_log.push_back(m_idx);
                end
                if (song_done === 1'b1) begin
                    sd_cnt++; last_sd_cyc = cyc;
                end
                if (reset_play) begin
                    m_busy = 0; m_wait = 0; m_end = 0; m_idx = 0;
                end else if (m_end) begin
                    m_end = 0; m_idx = 0;
                end else if (m_wait) begin
                    if (note_done) begin
                        m_wait = 0;
                        if (m_idx == 31) m_end = 1;
                        else begin m_idx++; m_busy = 1; m_step = 0; end
                    end
                end else if (m_busy) begin
                    if (play) begin
                        if (m_step == 0) m_step = 1;
                        else if (m_step == 1) begin
                            m_word = mem[{song, m_idx[4:0]}];
                            if (m_word[5:0] == 6'd0) begin m_busy = 0; m_end = 1; end
                            else begin m_note = m_word[11:6]; m_dur = m_word[5:0]; m_step = 2; end
                        end else begin
                            m_busy = 0; m_wait = 1;
                        end
                    end
                end else if (play) begin
                    m_busy = 1; m_step = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after each rising edge; a simple
    // note player answers each strobe after a random delay.
    // ------------------------------------------------------------------
    bit auto_done = 0;
    int spur_pct  = 0;
    int nn_seen   = 0;
    int cd        = -1;
    int done_cyc  = 0;

    task automatic tick();
        @(posedge clk); #1;
        note_done = 1'b0;
        if (auto_done) begin
            if (nn_cnt != nn_seen) begin nn_seen = nn_cnt; cd = $urandom_range(0, 3); end
            if (cd == 0) begin note_done = 1'b1; done_cyc = cyc + 1; end
            if (cd >= 0) cd--;
            if (!note_done && spur_pct > 0 && $urandom_range(0, 99) < spur_pct) note_done = 1'b1;
        end
    endtask

    task automatic run_until_nn(input int target, input int budget);
        int n = 0;
        while (nn_cnt < target && n < budget) begin tick(); n++; end
        chk("wait_new_note_timeout", nn_cnt >= target, 1);
    endtask

    task automatic run_until_sd(input int target, input int budget);
        int n = 0;
        while (sd_cnt < target && n < budget) begin tick(); n++; end
        chk("wait_song_done_timeout", sd_cnt >= target, 1);
    endtask

    task automatic fill_song(input int s, input int len);
        for (int i = 0; i < 32; i++) begin
            logic [5:0] n, d;
            n = 6'($urandom);
            d = (i < len) ? 6'($urandom_range(1, 63)) : 6'd0;
            mem[s*32 + i] = {n, d};
        end
    endtask

    task automatic restart_on(input logic [1:0] s);
        tick();
        reset_play = 1'b1; song = s; play = 1'b0;
        tick();
        reset_play = 1'b0;
        auto_done = 0; cd = -1; nn_seen = nn_cnt;
    endtask

    int p_cyc, base, sdb;

    initial begin
        reset = 1'b0; play = 1'b0; reset_play = 1'b0; note_done = 1'b0; song = 2'd2;
        fill_song(0, 20); fill_song(1, 32); fill_song(2, 3); fill_song(3, 5);
        mem[{2'd2, 5'd0}] = {6'h11, 6'h05};
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Test 1: first note of song 2
        play = 1'b1; p_cyc = cyc + 1; nn_seen = nn_cnt;
        chk("t1_rom_addr", rom_addr, 7'h40);
        run_until_nn(1, 10);
        chk("t1_latency", last_nn_cyc - p_cyc, 3);
        chk("t1_note", note, 6'h11);
        chk("t1_duration", duration, 6'h05);

        // Test 2: three-note song ended by a zero duration at index 3
        auto_done = 1;
        run_until_sd(1, 100);
        play = 1'b0;
        chk("t2_note_count", nn_cnt, 3);
        chk("t2_idx_log_size", idx_log.size(), 3);
        for (int k = 0; k < 3; k++) chk("t2_idx", idx_log[k], k);
        // note_done -> FETCH -> WAIT_ROM -> END
        chk("t2_sd_latency", last_sd_cyc - done_cyc, 3);
        chk("t2_addr_back", rom_addr, 7'h40);
        repeat (3) tick();
        chk("t2_stay_idle", nn_cnt, 3);

        // Test 3: full 32-word song
        restart_on(2'd1);
        idx_log.delete();
        base = nn_cnt; sdb = sd_cnt;
        play = 1'b1; auto_done = 1;
        run_until_sd(sdb + 1, 600);
        play = 1'b0;
        chk("t3_note_count", nn_cnt - base, 32);
        chk("t3_last_idx", idx_log[31], 31);
        chk("t3_sd_latency", last_sd_cyc - done_cyc, 1);
        chk("t3_addr_back", rom_addr, {2'd1, 5'd0});

        // Test 4: pause for 10 cycles in WAIT_ROM
        restart_on(2'd3);
        tick();
        play = 1'b1; p_cyc = cyc + 1;
        tick(); tick();
        play = 1'b0; base = nn_cnt;
        repeat (10) tick();
        chk("t4_no_note_in_pause", nn_cnt, base);
        play = 1'b1; p_cyc = cyc + 1;
        run_until_nn(base + 1, 10);
        chk("t4_resume_latency", last_nn_cyc - p_cyc, 1);
        chk("t4_note", last_nn_note, mem[{2'd3, 5'd0}][11:6]);
        auto_done = 1;
        run_until_sd(sd_cnt + 1, 200);
        play = 1'b0;

        // Test 5: reset_play together with note_done at index 7
        restart_on(2'd0);
        base = nn_cnt;
        play = 1'b1; auto_done = 1;
        run_until_nn(base + 8, 300);
        chk("t5_idx7", last_nn_idx, 7);
        auto_done = 0; cd = -1;
        note_done = 1'b1; reset_play = 1'b1; sdb = sd_cnt;
        tick();
        reset_play = 1'b0; play = 1'b0;
        repeat (5) tick();
        chk("t5_no_song_done", sd_cnt, sdb);
        chk("t5_addr_low", rom_addr[4:0], 0);
        base = nn_cnt; nn_seen = nn_cnt;
        play = 1'b1;
        run_until_nn(base + 1, 10);
        chk("t5_restart_idx", last_nn_idx, 0);
        chk("t5_restart_note", last_nn_note, mem[{2'd0, 5'd0}][11:6]);

        // Test 6: asynchronous reset in the middle of an ISSUE cycle
        restart_on(2'd2);
        tick();
        play = 1'b1;
        tick(); tick(); tick();
        #1 chk("t6_issue_strobe", new_note, 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_new_note_drop", new_note, 0);
        chk("t6_note_clear", note, 0);
        chk("t6_duration_clear", duration, 0);
        chk("t6_addr", rom_addr, 7'h40);
        chk("t6_song_done", song_done, 0);
        play = 1'b0;
        tick(); tick();
        reset = 1'b1;
        nn_seen = nn_cnt;

        // Random phase
        for (int s = 0; s < 4; s++) fill_song(s, $urandom_range(0, 32));
        sdb = sd_cnt; base = nn_cnt;
        auto_done = 1; spur_pct = 4; play = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 99) < 8) play = ($urandom_range(0, 3) != 0);
            reset_play = ($urandom_range(0, 199) == 0);
            if (reset_play) song = 2'($urandom);
        end
        reset_play = 1'b0; play = 1'b0;
        tick(); tick();
        chk("rand_activity", (nn_cnt > base) && (sd_cnt > sdb), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
